// File: rtl/ddr3_s4_amphy_phy_alt_mem_phy_pkg.sv
// Shared types and sizing for the ALTMEMPHY PLL phase-shift controller.
package ddr3_s4_amphy_phy_alt_mem_phy_pkg;

    localparam int unsigned STEP_W_DEF  = 2;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned STEPS_W     = 6;
    localparam int unsigned TO_W        = 10;
    localparam int unsigned CNTSEL_W    = 4;
    localparam int unsigned STEP_CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_STEP      = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4,
        ST_GAP       = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERR       = 3'd7
    } state_t;

    typedef struct packed {
        logic [CNTSEL_W-1:0] cntsel;
        logic                up;
    } req_t;

endpackage

// File: rtl/ddr3_s4_amphy_phy_alt_mem_phy_sync2.sv
// Two-flop synchronizer with synchronous active-low reset to 0.
module ddr3_s4_amphy_phy_alt_mem_phy_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl.sv
// PLL dynamic phase-shift sequencer: issues N phasestep pulses, each gated by
// a phasedone low/high handshake, aborting on timeout or loss of lock.
module ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl
    import ddr3_s4_amphy_phy_alt_mem_phy_pkg::*;
#(
    parameter int unsigned STEP_W  = STEP_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                scanclk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CNTSEL_W-1:0] req_cntsel,
    input  logic                req_up,
    input  logic [STEPS_W-1:0]  req_steps,
    output logic                done,
    output logic                err,
    output logic                busy,
    output logic [STEPS_W-1:0]  steps_left,
    input  logic                pll_locked,
    input  logic                pll_phasedone,
    output logic [CNTSEL_W-1:0] pll_phasecounterselect,
    output logic                pll_phasestep,
    output logic                pll_phaseupdown
);

    localparam int unsigned STEP_LAST = STEP_W - 1;
    localparam int unsigned TO_LAST   = TIMEOUT - 1;

    logic                  locked;
    logic                  phasedone;
    state_t                state_q, state_d;
    req_t                  req_q, req_d;
    logic [STEPS_W-1:0]    steps_left_q, steps_left_d;
    logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [CNTSEL_W-1:0]   cntsel_q, cntsel_d;
    logic                  updown_q, updown_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  step_q, step_d;

    ddr3_s4_amphy_phy_alt_mem_phy_sync2 u_sync_locked (
        .clk   (scanclk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (locked)
    );

    ddr3_s4_amphy_phy_alt_mem_phy_sync2 u_sync_phasedone (
        .clk   (scanclk),
        .rst_n (reset_n),
        .d     (pll_phasedone),
        .q     (phasedone)
    );

    always_ff @(posedge scanclk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            steps_left_q <= '0;
            step_cnt_q   <= '0;
            to_cnt_q     <= '0;
            cntsel_q     <= '0;
            updown_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            step_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            steps_left_q <= steps_left_d;
            step_cnt_q   <= step_cnt_d;
            to_cnt_q     <= to_cnt_d;
            cntsel_q     <= cntsel_d;
            updown_q     <= updown_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            step_q       <= step_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        steps_left_d = steps_left_q;
        step_cnt_d   = step_cnt_q;
        to_cnt_d     = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && locked) begin
                    req_d.cntsel = req_cntsel;
                    req_d.up     = req_up;
                    steps_left_d = req_steps;
                    state_d      = (req_steps == '0) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP, ST_GAP: begin
                step_cnt_d = '0;
                state_d    = ST_STEP;
            end
            ST_STEP: begin
                if (step_cnt_q == STEP_CNT_W'(STEP_LAST)) begin
                    to_cnt_d = '0;
                    state_d  = ST_WAIT_LOW;
                end else begin
                    step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
                end
            end
            ST_WAIT_LOW: begin
                if (!phasedone) begin
                    to_cnt_d = '0;
                    state_d  = ST_WAIT_HIGH;
                end else if (to_cnt_q == TO_W'(TO_LAST)) begin
                    state_d = ST_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (phasedone) begin
                    steps_left_d = steps_left_q - STEPS_W'(1);
                    state_d      = (steps_left_q == STEPS_W'(1)) ? ST_DONE : ST_GAP;
                end else if (to_cnt_q == TO_W'(TO_LAST)) begin
                    state_d = ST_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_DONE, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
        // Lock loss overrides everything and keeps the unfinished step count.
        if (!locked && !(state_q inside {ST_IDLE, ST_DONE, ST_ERR})) begin
            state_d      = ST_ERR;
            steps_left_d = steps_left_q;
        end
    end

    // Outputs registered from the next state so they line up with state_q
    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        err_d    = (state_d == ST_ERR);
        step_d   = (state_d == ST_STEP);
        cntsel_d = cntsel_q;
        updown_d = updown_q;
        if (state_d == ST_SETUP) begin
            cntsel_d = req_d.cntsel;
            updown_d = req_d.up;
        end else if (state_d == ST_IDLE) begin
            cntsel_d = '0;
            updown_d = 1'b0;
        end
    end

    assign req_ready              = (state_q == ST_IDLE) && locked;
    assign done                   = done_q;
    assign err                    = err_q;
    assign busy                   = busy_q;
    assign steps_left             = steps_left_q;
    assign pll_phasecounterselect = cntsel_q;
    assign pll_phasestep          = step_q;
    assign pll_phaseupdown        = updown_q;

endmodule

// File: tb/tb_ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl.sv
// Directed self-checking bench for the PLL phase-shift controller.
module tb_ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl;

    logic       scanclk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_cntsel;
    logic       req_up;
    logic [5:0] req_steps;
    logic       done;
    logic       err;
    logic       busy;
    logic [5:0] steps_left;
    logic       pll_locked;
    logic       pll_phasedone;
    logic [3:0] pll_phasecounterselect;
    logic       pll_phasestep;
    logic       pll_phaseupdown;

    int n_checks = 0;
    int n_fail   = 0;

    // PLL model: phasedone low for 4 cycles, starting 2 cycles after a phasestep rise
    logic model_on = 1'b1;
    logic ps_prev  = 1'b0;
    int   pd_cnt   = -1;

    always #5 scanclk = ~scanclk;

    always @(posedge scanclk) begin
        ps_prev <= pll_phasestep;
        if (model_on && pll_phasestep && !ps_prev) pd_cnt <= 0;
        else if (pd_cnt >= 0) pd_cnt <= (pd_cnt == 5) ? -1 : pd_cnt + 1;
    end

    assign pll_phasedone = !(pd_cnt >= 2 && pd_cnt <= 5);

    ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl #(
        .STEP_W  (2),
        .TIMEOUT (16)
    ) dut (
        .scanclk                (scanclk),
        .reset_n                (reset_n),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_cntsel             (req_cntsel),
        .req_up                 (req_up),
        .req_steps              (req_steps),
        .done                   (done),
        .err                    (err),
        .busy                   (busy),
        .steps_left             (steps_left),
        .pll_locked             (pll_locked),
        .pll_phasedone          (pll_phasedone),
        .pll_phasecounterselect (pll_phasecounterselect),
        .pll_phasestep          (pll_phasestep),
        .pll_phaseupdown        (pll_phaseupdown)
    );

    task automatic tick();
        @(posedge scanclk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({req_ready, done, err, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {req_ready, done, err, busy});
        end
        n_checks++;
        if (steps_left !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_steps_left: got %0d expected 0", steps_left);
        end
        n_checks++;
        if ({pll_phasecounterselect, pll_phasestep, pll_phaseupdown} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_pll_outs: got %b expected 000000",
                     {pll_phasecounterselect, pll_phasestep, pll_phaseupdown});
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_sync: got %b expected 0", req_ready);
        end
        tick();
        tick();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_locked: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_basic();
        int pulses, width, bad_width, unstable, dones, errs;
        bit fin, prev_ps;
        pulses = 0; width = 0; bad_width = 0; unstable = 0; dones = 0; errs = 0;
        fin = 1'b0; prev_ps = 1'b0;
        model_on   = 1'b1;
        req_cntsel = 4'h2;
        req_up     = 1'b1;
        req_steps  = 6'd3;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (busy && (pll_phasecounterselect !== 4'h2 || pll_phaseupdown !== 1'b1)) unstable++;
            if (pll_phasestep && !prev_ps) pulses++;
            if (pll_phasestep) width++;
            else if (prev_ps) begin
                if (width != 2) bad_width++;
                width = 0;
            end
            prev_ps = pll_phasestep;
            if (done) dones++;
            if (err) errs++;
            if (!busy) fin = 1'b1;
            else tick();
        end
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL basic_complete: got busy=%b expected idle within 300 cycles", busy);
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL basic_pulses: got %0d expected 3", pulses);
        end
        n_checks++;
        if (bad_width != 0) begin
            n_fail++;
            $display("FAIL basic_pulse_width: got %0d bad pulses expected 0", bad_width);
        end
        n_checks++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL basic_cntsel_updown: got %0d unstable cycles expected 0", unstable);
        end
        n_checks++;
        if (dones != 1 || errs != 0) begin
            n_fail++;
            $display("FAIL basic_done_err: got done=%0d err=%0d expected 1 0", dones, errs);
        end
        n_checks++;
        if (steps_left !== 6'd0) begin
            n_fail++;
            $display("FAIL basic_steps_left: got %0d expected 0", steps_left);
        end
    endtask

    task automatic test_zero_steps();
        req_steps = 6'd0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({done, busy, pll_phasestep, err} !== 4'b1100) begin
            n_fail++;
            $display("FAIL zero_done_cycle: got done,busy,step,err=%b expected 1100",
                     {done, busy, pll_phasestep, err});
        end
        tick();
        n_checks++;
        if ({done, busy, pll_phasestep} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_after: got done,busy,step=%b expected 000", {done, busy, pll_phasestep});
        end
    endtask

    task automatic test_timeout();
        int first_err, pulses, err_steps;
        bit prev_ps;
        first_err = 0; pulses = 0; err_steps = -1; prev_ps = 1'b0;
        model_on   = 1'b0;
        req_cntsel = 4'h5;
        req_up     = 1'b0;
        req_steps  = 6'd5;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int idx = 1; idx <= 60 && first_err == 0; idx++) begin
            if (pll_phasestep && !prev_ps) pulses++;
            prev_ps = pll_phasestep;
            if (err) begin
                first_err = idx;
                err_steps = int'(steps_left);
            end else begin
                tick();
            end
        end
        n_checks++;
        if (first_err != 20) begin
            n_fail++;
            $display("FAIL timeout_err_cycle: got %0d expected 20", first_err);
        end
        n_checks++;
        if (err_steps != 5) begin
            n_fail++;
            $display("FAIL timeout_steps_left: got %0d expected 5", err_steps);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL timeout_pulses: got %0d expected 1", pulses);
        end
        tick();
        n_checks++;
        if ({err, busy, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL timeout_after: got err,busy,ready=%b expected 001", {err, busy, req_ready});
        end
        model_on = 1'b1;
    endtask

    task automatic test_lock_loss();
        int rises, k_err, err_steps, bad_ready;
        bit prev_ps, dropped;
        rises = 0; k_err = 0; err_steps = -1; bad_ready = 0; prev_ps = 1'b0; dropped = 1'b0;
        req_cntsel = 4'h1;
        req_up     = 1'b1;
        req_steps  = 6'd4;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 200 && !dropped; c++) begin
            if (pll_phasestep && !prev_ps) rises++;
            prev_ps = pll_phasestep;
            if (rises == 2) begin
                pll_locked = 1'b0;
                dropped    = 1'b1;
            end else begin
                tick();
            end
        end
        n_checks++;
        if (!dropped) begin
            n_fail++;
            $display("FAIL lock_second_step: got %0d steps expected 2 within 200 cycles", rises);
        end
        for (int k = 1; k <= 6 && k_err == 0; k++) begin
            tick();
            if (err) begin
                k_err     = k;
                err_steps = int'(steps_left);
            end
        end
        n_checks++;
        if (k_err < 1 || k_err > 4) begin
            n_fail++;
            $display("FAIL lock_err_latency: got %0d expected 1..4", k_err);
        end
        n_checks++;
        if (err_steps != 3) begin
            n_fail++;
            $display("FAIL lock_steps_left: got %0d expected 3", err_steps);
        end
        req_steps = 6'd2;
        req_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (req_ready !== 1'b0 || busy !== 1'b0) bad_ready++;
        end
        n_checks++;
        if (bad_ready != 0) begin
            n_fail++;
            $display("FAIL lock_held_off: got %0d cycles ready/busy expected 0", bad_ready);
        end
        req_valid  = 1'b0;
        pll_locked = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        n_checks++;
        if ({req_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL lock_restored: got ready,busy=%b expected 10", {req_ready, busy});
        end
    endtask

    task automatic test_reset_mid();
        bit seen_low, fin;
        int pulses, dones;
        seen_low = 1'b0; fin = 1'b0; pulses = 0; dones = 0;
        req_cntsel = 4'h3;
        req_up     = 1'b1;
        req_steps  = 6'd3;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 100 && !seen_low; c++) begin
            if (pll_phasedone === 1'b0) seen_low = 1'b1;
            else tick();
        end
        n_checks++;
        if (!seen_low) begin
            n_fail++;
            $display("FAIL rmid_phasedone_low: got %b expected 0 within 100 cycles", pll_phasedone);
        end
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        n_checks++;
        if ({req_ready, done, err, busy, steps_left, pll_phasecounterselect,
             pll_phasestep, pll_phaseupdown} !== 16'd0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got ready=%b done=%b err=%b busy=%b left=%0d sel=%0d step=%b ud=%b expected all 0",
                     req_ready, done, err, busy, steps_left, pll_phasecounterselect,
                     pll_phasestep, pll_phaseupdown);
        end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done || err) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL rmid_no_pulse: got %0d done/err cycles expected 0", pulses);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_ready: got %b expected 1", req_ready);
        end
        req_steps = 6'd1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (done) dones++;
            if (!busy) fin = 1'b1;
            else tick();
        end
        n_checks++;
        if (!fin || dones != 1) begin
            n_fail++;
            $display("FAIL rmid_new_request: got fin=%b done=%0d expected 1 1", fin, dones);
        end
    endtask

    task automatic test_back_to_back();
        int accepts, viol, d1, n_done, a2;
        accepts = 0; viol = 0; d1 = -1; n_done = 0; a2 = -1;
        req_cntsel = 4'h7;
        req_up     = 1'b0;
        req_steps  = 6'd1;
        req_valid  = 1'b1;
        for (int idx = 0; idx < 200 && n_done < 2; idx++) begin
            if (req_ready && busy) viol++;
            if (req_valid && req_ready) begin
                accepts++;
                if (accepts == 2) a2 = idx;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) d1 = idx;
                else req_valid = 1'b0;
            end
            tick();
        end
        req_valid = 1'b0;
        n_checks++;
        if (n_done != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d expected 2 within 200 cycles", n_done);
        end
        n_checks++;
        if (a2 != d1 + 1) begin
            n_fail++;
            $display("FAIL b2b_second_accept: got cycle %0d expected %0d", a2, d1 + 1);
        end
        n_checks++;
        if (accepts != 2 || viol != 0) begin
            n_fail++;
            $display("FAIL b2b_accepts: got accepts=%0d ready_while_busy=%0d expected 2 0", accepts, viol);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        req_valid  = 1'b0;
        req_cntsel = 4'h0;
        req_up     = 1'b0;
        req_steps  = 6'd0;
        test_reset();
        test_basic();
        test_zero_steps();
        test_timeout();
        for (int c = 0; c < 10; c++) tick();
        test_lock_loss();
        for (int c = 0; c < 10; c++) tick();
        test_reset_mid();
        for (int c = 0; c < 10; c++) tick();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
